// File: rtl/gravity_pkg.sv
// ---------------------------------------------------------------------------
// gravity_pkg
// Shared definitions for the gravity-direction controller:
//   - FSM state encoding (S_DOWN, S_UP, S_COOL)
//   - gravity direction constants (DIR_DOWN, DIR_UP)
//   - helpers for mapping a direction to its idle state and sizing counters
// ---------------------------------------------------------------------------
package gravity_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_DOWN = 2'd0;
    localparam state_t S_UP   = 2'd1;
    localparam state_t S_COOL = 2'd2;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Idle state that corresponds to a given gravity direction.
    function automatic state_t idle_state(input logic d);
        return (d == DIR_UP) ? S_UP : S_DOWN;
    endfunction

    // Bits needed to hold the values 0..n; at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/line_contact_detect.sv
// ---------------------------------------------------------------------------
// line_contact_detect
// Comparator bank plus priority encoder: decides whether the player height
// sits exactly on the contact height of an enabled platform line for the
// current gravity direction.
//
// Ports:
//   height        in   H_W        player height from physics
//   lines         in   NUM_LINES  per-line enable, bit i = line i present
//   dir           in   1          current gravity direction
//   contact       out  1          some enabled line matches
//   contact_line  out  CL_W       lowest matching line index, 0 if none
// ---------------------------------------------------------------------------
module line_contact_detect
    import gravity_pkg::*;
#(
    parameter int NUM_LINES  = 3,
    parameter int H_W        = 9,
    parameter int DOWN_BASE  = 120,
    parameter int UP_BASE    = 60,
    parameter int LINE_PITCH = 120,
    parameter int CL_W       = 2
) (
    input  logic [H_W-1:0]       height,
    input  logic [NUM_LINES-1:0] lines,
    input  logic                 dir,
    output logic                 contact,
    output logic [CL_W-1:0]      contact_line
);

    localparam int EXT_W = H_W + 8;

    logic [NUM_LINES-1:0] hit;

    // Contact heights are evaluated 8 bits wider than the height input. A
    // height that does not fit in H_W bits keeps a non-zero upper byte, so the
    // zero-extended player height can never equal it and that line is inert.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        localparam logic [EXT_W-1:0] DOWN_H = EXT_W'(DOWN_BASE + i * LINE_PITCH);
        localparam logic [EXT_W-1:0] UP_H   = EXT_W'(UP_BASE + i * LINE_PITCH);

        assign hit[i] = lines[i] &&
                        ({8'd0, height} == ((dir == DIR_UP) ? UP_H : DOWN_H));
    end

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        contact      = |hit;
        contact_line = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                contact_line = CL_W'(i);
            end
        end
    end

endmodule

// File: rtl/gravity_flip_ctrl.sv
// ---------------------------------------------------------------------------
// gravity_flip_ctrl
// Gravity-direction controller for the player sprite. The direction flips on
// a rising edge of the flip button while the player stands on an enabled
// platform line; a tick-based cooldown follows every flip.
//
// Build option: define FLIP_BUFFER_EN to buffer presses that cannot flip
// immediately (no contact, or during cooldown) for BUF_TICKS ticks.
//
// Ports:
//   clk           in   1          system clock
//   reset         in   1          asynchronous, active-low reset
//   tick          in   1          one-cycle game-frame strobe
//   switch        in   1          debounced flip button (level)
//   lines         in   NUM_LINES  per-line enable
//   height        in   H_W        current player height
//   dir           out  1          gravity direction (0 down, 1 up), registered
//   flip_pulse    out  1          one-cycle strobe in the cycle after a flip
//   contact       out  1          player is on a contact height (combinational)
//   contact_line  out  CL_W       index of the contacting line, 0 if none
//   busy          out  1          cooldown active
// ---------------------------------------------------------------------------
module gravity_flip_ctrl
    import gravity_pkg::*;
#(
    parameter int NUM_LINES  = 3,
    parameter int H_W        = 9,
    parameter int DOWN_BASE  = 120,
    parameter int UP_BASE    = 60,
    parameter int LINE_PITCH = 120,
    parameter int COOL_TICKS = 8
`ifdef FLIP_BUFFER_EN
    ,
    parameter int BUF_TICKS  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 switch,
    input  logic [NUM_LINES-1:0] lines,
    input  logic [H_W-1:0]       height,
    output logic                 dir,
    output logic                 flip_pulse,
    output logic                 contact,
    output logic [((NUM_LINES > 1) ? $clog2(NUM_LINES) : 1)-1:0] contact_line,
    output logic                 busy
);

    localparam int CL_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_W = cnt_width(COOL_TICKS);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_TICKS);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             switch_q;

    logic press;
    logic idle;
    logic want_flip;
    logic flip_now;

    // -----------------------------------------------------------------------
    // Contact detection
    // -----------------------------------------------------------------------
    line_contact_detect #(
        .NUM_LINES  (NUM_LINES),
        .H_W        (H_W),
        .DOWN_BASE  (DOWN_BASE),
        .UP_BASE    (UP_BASE),
        .LINE_PITCH (LINE_PITCH),
        .CL_W       (CL_W)
    ) u_contact (
        .height       (height),
        .lines        (lines),
        .dir          (dir_q),
        .contact      (contact),
        .contact_line (contact_line)
    );

    // A held button yields exactly one press: only the 0->1 transition counts.
    assign press = switch & ~switch_q;
    assign idle  = (state_q == S_DOWN) || (state_q == S_UP);

`ifdef FLIP_BUFFER_EN
    // -----------------------------------------------------------------------
    // Press buffer: remembers a press that could not flip for BUF_TICKS ticks
    // -----------------------------------------------------------------------
    localparam int BUF_W = cnt_width(BUF_TICKS);
    localparam logic [BUF_W-1:0] BUF_LOAD = BUF_W'(BUF_TICKS);

    logic             buf_q, buf_d;
    logic [BUF_W-1:0] buf_cnt_q, buf_cnt_d;

    assign want_flip = press | buf_q;

    always_comb begin
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        if (flip_now) begin
            // Whatever triggered the flip, the buffered request is consumed.
            buf_d     = 1'b0;
            buf_cnt_d = '0;
        end else if (press) begin
            // A press that did not flip (re)arms the buffer; a zero lifetime
            // means the buffer never holds anything.
            buf_d     = (BUF_TICKS > 0);
            buf_cnt_d = BUF_LOAD;
        end else if (buf_q && tick) begin
            if (buf_cnt_q <= BUF_W'(1)) begin
                buf_d     = 1'b0;
                buf_cnt_d = '0;
            end else begin
                buf_cnt_d = buf_cnt_q - BUF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q     <= 1'b0;
            buf_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end
`else
    assign want_flip = press;
`endif

    assign flip_now = idle && contact && want_flip;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, regardless of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_DOWN;
            dir_q    <= DIR_DOWN;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            switch_q <= switch;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        case (state_q)
            S_DOWN, S_UP: begin
                // A press without contact simply falls through here.
                if (flip_now) begin
                    dir_d   = ~dir_q;
                    pulse_d = 1'b1;
                    if (COOL_TICKS > 0) begin
                        state_d = S_COOL;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        state_d = idle_state(~dir_q);
                    end
                end
            end

            S_COOL: begin
                // Presses are ignored here; only ticks matter. The tick that
                // takes the counter from 1 to 0 ends the cooldown, even if a
                // press arrives in the same cycle.
                if (tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = idle_state(dir_q);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                // Unused encoding: recover to the idle state matching dir.
                state_d = idle_state(dir_q);
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        dir        = dir_q;
        flip_pulse = pulse_q;
        busy       = (state_q == S_COOL);
    end

endmodule

// File: tb/tb_gravity_flip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gravity_flip_ctrl
// Self-checking bench for gravity_flip_ctrl with default parameters.
// Table-driven contact checks, directed multi-cycle sequences, then a
// randomized run against a behavioural reference model. Honours
// FLIP_BUFFER_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_gravity_flip_ctrl;

    localparam int NL         = 3;
    localparam int HW         = 9;
    localparam int DOWN_BASE  = 120;
    localparam int UP_BASE    = 60;
    localparam int LINE_PITCH = 120;
    localparam int COOL_TICKS = 8;
    localparam int BUF_TICKS  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          switch;
    logic [NL-1:0] lines;
    logic [HW-1:0] height;
    logic          dir;
    logic          flip_pulse;
    logic          contact;
    logic [1:0]    contact_line;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    gravity_flip_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .switch       (switch),
        .lines        (lines),
        .height       (height),
        .dir          (dir),
        .flip_pulse   (flip_pulse),
        .contact      (contact),
        .contact_line (contact_line),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick_once();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(2);
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    // Contact computed straight from the line geometry.
    function automatic void model_contact(input logic d, input logic [NL-1:0] ln,
                                          input logic [HW-1:0] h,
                                          output logic c, output logic [1:0] idx);
        c   = 1'b0;
        idx = 2'd0;
        for (int i = 0; i < NL; i++) begin
            int ch;
            ch = (d ? UP_BASE : DOWN_BASE) + i * LINE_PITCH;
            if (!c && ln[i] && ch < (1 << HW) && int'(h) == ch) begin
                c   = 1'b1;
                idx = 2'(i);
            end
        end
    endfunction

    // -----------------------------------------------------------------------
    // Contact vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic          d;
        logic [NL-1:0] ln;
        logic [HW-1:0] h;
        logic          c;
        logic [1:0]    idx;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    // -----------------------------------------------------------------------
    // Reference model state for the random phase
    // -----------------------------------------------------------------------
    logic m_dir, m_pulse, m_sw, m_buf;
    int   m_cool, m_bcnt;

    initial begin
        logic exp_c;
        logic [1:0] exp_idx;
        logic sw;
        logic [HW-1:0] hsel [8];

        vecs[0]  = '{1'b0, 3'b111, 9'd120, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 3'b111, 9'd240, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 3'b111, 9'd360, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 3'b110, 9'd120, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 3'b011, 9'd360, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 3'b111, 9'd121, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 3'b111, 9'd60,  1'b0, 2'd0};
        vecs[7]  = '{1'b0, 3'b100, 9'd360, 1'b1, 2'd2};
        vecs[8]  = '{1'b0, 3'b111, 9'd0,   1'b0, 2'd0};
        vecs[9]  = '{1'b1, 3'b111, 9'd60,  1'b1, 2'd0};
        vecs[10] = '{1'b1, 3'b111, 9'd180, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 3'b111, 9'd300, 1'b1, 2'd2};
        vecs[12] = '{1'b1, 3'b111, 9'd120, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 3'b101, 9'd180, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 3'b100, 9'd300, 1'b1, 2'd2};

        hsel = '{9'd60, 9'd120, 9'd180, 9'd240, 9'd300, 9'd360, 9'd100, 9'd0};

        // ---------------- reset state (asynchronous) ----------------
        reset  = 1'b0;
        tick   = 1'b0;
        switch = 1'b0;
        lines  = '0;
        height = '0;
        #12;
        check("reset.dir", 32'(dir), 32'(0));
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.flip_pulse", 32'(flip_pulse), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // ---------------- contact table, dir = 0 ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].d == 1'b0) begin
                lines  = vecs[i].ln;
                height = vecs[i].h;
                #1;
                check($sformatf("table[%0d].contact", i), 32'(contact), 32'(vecs[i].c));
                check($sformatf("table[%0d].line", i), 32'(contact_line), 32'(vecs[i].idx));
            end
        end

        // ---------------- first flip ----------------
        cyc();
        lines  = 3'b001;
        height = 9'd120;
        cyc();
        switch = 1'b1;
        #1;
        check("flip1.contact_before", 32'(contact), 32'(1));
        check("flip1.dir_before", 32'(dir), 32'(0));
        cyc();
        check("flip1.dir", 32'(dir), 32'(1));
        check("flip1.pulse", 32'(flip_pulse), 32'(1));
        check("flip1.busy", 32'(busy), 32'(1));
        check("flip1.contact_after", 32'(contact), 32'(0));
        switch = 1'b0;
        cyc();
        check("flip1.pulse_one_cycle", 32'(flip_pulse), 32'(0));
        check("flip1.dir_held", 32'(dir), 32'(1));

        // ---------------- contact table, dir = 1 ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].d == 1'b1) begin
                lines  = vecs[i].ln;
                height = vecs[i].h;
                #1;
                check($sformatf("table[%0d].contact", i), 32'(contact), 32'(vecs[i].c));
                check($sformatf("table[%0d].line", i), 32'(contact_line), 32'(vecs[i].idx));
            end
        end

        // ---------------- cooldown boundary: 7 ticks vs 8 ticks ----------------
        lines  = 3'b111;
        height = 9'd180;
        ticks(7);
        check("cool7.busy", 32'(busy), 32'(1));
        check("cool7.contact", 32'(contact), 32'(1));
        check("cool7.line", 32'(contact_line), 32'(1));
        switch = 1'b1;
        cyc();
        switch = 1'b0;
        check("cool7.press_ignored", 32'(dir), 32'(1));
        check("cool7.no_pulse", 32'(flip_pulse), 32'(0));
        cyc();
        tick_once();
        check("cool8.busy", 32'(busy), 32'(0));
        check("cool8.dir", 32'(dir), 32'(1));
        switch = 1'b1;
        cyc();
        check("cool8.flip_back", 32'(dir), 32'(0));
        check("cool8.pulse", 32'(flip_pulse), 32'(1));
        switch = 1'b0;
        cyc();

        // ---------------- held switch across a flip ----------------
        ticks(COOL_TICKS);
        check("held.idle", 32'(busy), 32'(0));
        height = 9'd120;
        switch = 1'b1;
        cyc();
        check("held.flip", 32'(dir), 32'(1));
        height = 9'd180;
        ticks(COOL_TICKS);
        check("held.cool_done", 32'(busy), 32'(0));
        cycles(5);
        check("held.no_second_flip", 32'(dir), 32'(1));
        check("held.no_pulse", 32'(flip_pulse), 32'(0));
        switch = 1'b0;
        cyc();
        switch = 1'b1;
        cyc();
        check("held.repress_flip", 32'(dir), 32'(0));
        switch = 1'b0;
        cyc();

        // ---------------- disabled line ----------------
        ticks(COOL_TICKS);
        height = 9'd240;
        lines  = 3'b101;
        #1;
        check("disabled.contact", 32'(contact), 32'(0));
        switch = 1'b1;
        cyc();
        switch = 1'b0;
        cyc();
        check("disabled.no_flip", 32'(dir), 32'(0));
        lines = 3'b111;
        #1;
        check("enabled.contact", 32'(contact), 32'(1));
        check("enabled.line", 32'(contact_line), 32'(1));
        switch = 1'b1;
        cyc();
        switch = 1'b0;
        check("enabled.flip", 32'(dir), 32'(1));
        check("enabled.busy", 32'(busy), 32'(1));
        check("enabled.pulse", 32'(flip_pulse), 32'(1));

        // ---------------- asynchronous reset mid-cooldown ----------------
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.dir", 32'(dir), 32'(0));
        check("async_rst.busy", 32'(busy), 32'(0));
        check("async_rst.pulse", 32'(flip_pulse), 32'(0));
        cycles(2);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // ---------------- press buffer ----------------
        lines  = 3'b001;
        height = 9'd100;
        switch = 1'b1;
        cyc();
        switch = 1'b0;
        ticks(2);
        height = 9'd120;
        cyc();
`ifdef FLIP_BUFFER_EN
        check("buffer.flip_within_life", 32'(dir), 32'(1));
`else
        check("buffer.discarded", 32'(dir), 32'(0));
`endif
        do_reset();
        height = 9'd100;
        switch = 1'b1;
        cyc();
        switch = 1'b0;
        ticks(5);
        height = 9'd120;
        cycles(3);
        check("buffer.expired", 32'(dir), 32'(0));

        // ---------------- randomized run against the model ----------------
        tick   = 1'b0;
        switch = 1'b0;
        do_reset();
        m_dir   = 1'b0;
        m_pulse = 1'b0;
        m_sw    = 1'b0;
        m_buf   = 1'b0;
        m_cool  = 0;
        m_bcnt  = 0;
        sw      = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic press, idle, want;
            if ($urandom_range(0, 3) == 0) sw = ~sw;
            switch = sw;
            tick   = ($urandom_range(0, 3) == 0);
            lines  = NL'($urandom);
            if ($urandom_range(0, 4) != 0) height = hsel[$urandom_range(0, 7)];
            else                           height = HW'($urandom);

            @(negedge clk);
            model_contact(m_dir, lines, height, exp_c, exp_idx);
            check("rand.dir", 32'(dir), 32'(m_dir));
            check("rand.pulse", 32'(flip_pulse), 32'(m_pulse));
            check("rand.busy", 32'(busy), 32'(m_cool > 0));
            check("rand.contact", 32'(contact), 32'(exp_c));
            check("rand.line", 32'(contact_line), 32'(exp_idx));

            // Advance the model by one clock.
            press   = switch && !m_sw;
            idle    = (m_cool == 0);
            want    = press || m_buf;
            m_pulse = 1'b0;
            if (idle && exp_c && want) begin
                m_dir   = ~m_dir;
                m_pulse = 1'b1;
                m_cool  = COOL_TICKS;
                m_buf   = 1'b0;
            end else begin
                if (!idle && tick) m_cool--;
`ifdef FLIP_BUFFER_EN
                if (press) begin
                    m_buf  = 1'b1;
                    m_bcnt = BUF_TICKS;
                end else if (m_buf && tick) begin
                    m_bcnt--;
                    if (m_bcnt == 0) m_buf = 1'b0;
                end
`endif
            end
            m_sw = switch;

            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gravity_flip_ctrl.md
Name: gravity_flip_ctrl

Overview:
Parametrised gravity-direction controller for the player sprite.
- Holds the gravity direction (0 = downward/normal, 1 = upward/reversed).
- Flips it on a rising edge of the flip button, only while the player is in contact with an enabled platform line.
- Generalised to N lines at evenly pitched heights, with rising-edge detection, a tick-based post-flip cooldown, and status outputs for the renderer and the physics block.

Parameters:
- NUM_LINES, 3, number of platform lines; line index 0 is lowest on screen.
- H_W, 9, width of the height input.
- DOWN_BASE, 120, contact height on line 0 under downward gravity.
- UP_BASE, 60, contact height on line 0 under upward gravity.
- LINE_PITCH, 120, height step between successive lines.
- COOL_TICKS, 8, tick count after a flip during which presses are ignored; 0 disables cooldown.
- BUF_TICKS, 4, press-buffer lifetime in ticks (used only with FLIP_BUFFER_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle game-frame strobe; drives the cooldown and buffer counters.
- switch  in  1  debounced flip button, level.
- lines  in  NUM_LINES  per-line enable; bit i = line i is present.
- height  in  H_W  current player height from physics.
- dir  out  1  gravity direction, registered.
- flip_pulse  out  1  one-cycle strobe in the cycle after dir changes.
- contact  out  1  combinational: player is at a contact height of an enabled line for the current dir.
- contact_line  out  max(1,$clog2(NUM_LINES))  index of the contacting line; 0 when contact=0.
- busy  out  1  high while cooldown is active.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values: dir=0, flip_pulse=0, busy=0, switch_q=0, cooldown counter=0, buffer cleared; FSM enters S_DOWN.
- Contact heights for line i:
  - dir=0: DOWN_BASE + i*LINE_PITCH
  - dir=1: UP_BASE + i*LINE_PITCH
  - Compute at H_W+8 bits; any line whose contact height does not fit in H_W bits never matches.
- contact is set when height equals the contact height of some line i for the current dir AND lines[i]=1.
- Contact priority: if several lines match (degenerate parameters), the lowest index wins for contact_line.
- Press detection: press = switch & ~switch_q, where switch_q is switch registered every clk. A held button produces exactly one press.
- FSM states:
  - S_DOWN: dir=0.
  - S_UP: dir=1.
  - S_COOL: dir is held at its current value.
- Transitions:
  - In S_DOWN or S_UP, if press & contact in cycle n: dir inverts at the clk edge ending cycle n and flip_pulse=1 during cycle n+1.
  - After that flip: if COOL_TICKS>0, go to S_COOL with counter=COOL_TICKS; otherwise go to the opposite idle state.
  - In S_DOWN or S_UP, a press without contact is discarded.
  - In S_COOL: busy=1. On each tick the counter decrements; when a tick occurs with counter=1, the counter reaches 0 and the FSM returns to S_DOWN/S_UP according to dir on the next edge.
  - In S_COOL, presses are ignored.
- Simultaneous press and tick while in S_COOL with counter=1: exit cooldown; the press is discarded.
- lines or height changing during S_COOL has no effect on dir.
- Reset asserted mid-cooldown or mid-buffer: everything returns to reset values immediately, with dir=0.
- contact reflects the new dir in the cycle after a flip, so contact normally drops then.

Optional Feature:
- Macro: FLIP_BUFFER_EN.
- Defined:
  - A press that cannot flip is latched into a 1-bit buffer with a counter loaded to BUF_TICKS. This covers a press with no contact in S_DOWN/S_UP, and a press during S_COOL.
  - The buffer counter decrements on tick; the buffer clears when it reaches 0.
  - While the buffer is set in S_DOWN/S_UP and contact=1, the flip executes exactly as a press would, and the buffer clears.
  - A new press while the buffer is set reloads the counter.
- Undefined: no buffer logic; presses without an immediate legal flip are discarded.

Decomposition:
- Shared package gravity_pkg:
  - state encoding localparams S_DOWN=2'd0, S_UP=2'd1, S_COOL=2'd2;
  - DIR_DOWN=1'b0, DIR_UP=1'b1.
- Natural sub-module line_contact_detect: parametrised comparator bank plus priority encoder producing contact and contact_line from height, lines and dir.

Test Plan:
- Reset, then height=120, lines=3'b001, switch pulse 0→1 → dir=1 one cycle later, flip_pulse high for exactly one cycle, busy=1.
- Held switch across a flip with height=180 → no second flip after the cooldown expires until switch drops and rises again.
- dir=0, height=240, lines=3'b101 (line 1 disabled), press → no flip; then lines=3'b111 and a fresh press → dir=1.
- After a flip with COOL_TICKS=8: press after 7 ticks → ignored; press after the 8th tick → flips back.
- Reset driven low while busy=1 → dir=0, busy=0, flip_pulse=0 asynchronously.
- FLIP_BUFFER_EN, BUF_TICKS=4: press at height=100, height reaches 120 after 2 ticks → flip; same sequence but after 5 ticks → no flip.
